multdiv_sequencer: RTL and testbench
====================================

# multdiv_sequencer

Multi-cycle multiply/divide sequencer for the processor datapath. It sits beside the single-cycle ALU in the execute stage and accepts R-type instructions (opcode 00000) whose ALU-op field selects mul (00110) or div (00111). It holds the pipeline with a stall signal while it runs the shift-add multiply or restoring divide, then presents one result for writeback with its destination register. It also flags overflow and divide-by-zero.

## Interface
- DATA_W, 32, operand and result width; iteration count equals DATA_W.
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; returns block to IDLE.
- issue  in  1  execute stage holds a valid instruction this cycle.
- opcode  in  5  instruction opcode field.
- aluop  in  5  instruction ALU-op field.
- rd  in  5  destination register of the issued instruction.
- opA  in  DATA_W  rs operand (signed).
- opB  in  DATA_W  rt operand (signed).
- stall  out  1  freeze fetch/decode/execute.
- result  out  DATA_W  product or quotient.
- result_valid  out  1  one-cycle pulse; result/result_rd/exc valid.
- result_rd  out  5  destination register for result.
- exc  out  1  overflow (mul) or divide-by-zero (div), qualified by result_valid.
- exc_code  out  DATA_W  rstatus value: 4 for mul overflow, 5 for div-by-zero, 0 otherwise.

## Operation
- md_go = issue & opcode==00000 & aluop in {00110, 00111}; other instructions are ignored.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - On md_go, latch rd and operand magnitudes; record result sign (XOR of sign bits); clear the counter.
  - mul -> MUL. div with opB!=0 -> DIV. div with opB==0 -> DONE (no iteration, result 0).
- MUL: radix-2 shift-add on a 2*DATA_W accumulator; one multiplier bit per cycle; DATA_W cycles, then DONE.
- DIV: restoring division on magnitudes; one quotient bit per cycle; DATA_W cycles, then DONE.
- DONE:
  - Apply sign correction: two's complement of magnitude when the sign is negative. Quotient truncates toward zero; the remainder is discarded.
  - Pulse result_valid for one cycle, then go to IDLE.
- Overflow (mul): the full signed 2*DATA_W product is not equal to the sign-extension of its low DATA_W bits. result still carries the low DATA_W bits.
- Special case: most-negative / -1 returns most-negative, with no exception.
- md_go while not IDLE is ignored; no queuing.

## Timing
- Reset values: state IDLE; stall, result_valid, exc = 0; result, result_rd, exc_code = 0.
- stall = md_go in IDLE (combinational) OR state in {MUL, DIV}. It is low in DONE, so the pipeline advances in the same cycle writeback consumes result.
- Latency: md_go sampled at edge 0. result_valid is high in the cycle after edge DATA_W+1 for mul and div (33 cycles at DATA_W=32). For divide-by-zero it is high after edge 1.
- result, result_rd, exc, exc_code are registered. They hold their last values until the next DONE.
- Reset asserted in any state aborts the operation next edge. No result_valid is produced for the aborted instruction.
- md_go in the DONE cycle is ignored. The pipeline has just been released and re-presents the instruction next cycle.

## Configuration
- MULTDIV_EXC_EN defined:
  - exc and exc_code are driven as described.
  - Divide-by-zero takes the 1-cycle short path.
- MULTDIV_EXC_EN undefined:
  - exc and exc_code are tied 0; overflow detection logic is removed.
  - Divide-by-zero still takes the short path and returns result 0.

## Test plan
- mul 6 x 7, rd=3 -> stall high 33 cycles; result_valid one cycle with result=42, result_rd=3, exc=0.
- div -12 / 5, rd=9 -> result=-2 (0xFFFFFFFE), result_valid after edge 33, exc=0.
- div 17 / 0 (EXC_EN) -> result_valid after edge 1, result=0, exc=1, exc_code=5; without macro: exc=0, exc_code=0.
- mul 0x00010000 x 0x00010000 -> result=0, exc=1, exc_code=4; mul -65536 x 32768 -> result=0x80000000, exc=0.
- Assert reset at cycle 10 of a mul -> next cycle stall=0, state IDLE; no result_valid ever; a new mul 3x3 then gives 9.
- md_go held during MUL with a different rd, plus a non-md opcode (addi 00101) in IDLE -> both ignored; only the original result is produced, and stall never rises for addi.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: multi-cycle shift-add multiply / restoring divide.
// Optional MULTDIV_EXC_EN drives exc/exc_code (mul overflow, div-by-zero).
module multdiv_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue,
  input  logic [4:0]        opcode,
  input  logic [4:0]        aluop,
  input  logic [4:0]        rd,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  output logic              stall,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [4:0]        result_rd,
  output logic              exc,
  output logic [DATA_W-1:0] exc_code
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [4:0] OpR    = 5'b00000;
  localparam logic [4:0] AluMul = 5'b00110;
  localparam logic [4:0] AluDiv = 5'b00111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, stateNext;

  logic                isMulOp, isDivOp, mdGo, lastIter;
  logic [CW-1:0]       cnt;
  logic [DATA_W-1:0]   magA, magB, opMag;
  logic [2*DATA_W-1:0] acc;
  logic                negRes, divOp, divZero;
  logic [4:0]          rdReg;
  logic [DATA_W:0]     mulSum, divShift, divTrial;
  logic                divFits;
  logic [DATA_W-1:0]   resMag, resNext;

  assign isMulOp  = issue && opcode == OpR && aluop == AluMul;
  assign isDivOp  = issue && opcode == OpR && aluop == AluDiv;
  assign mdGo     = isMulOp || isDivOp;
  assign magA     = opA[DATA_W-1] ? -opA : opA;
  assign magB     = opB[DATA_W-1] ? -opB : opB;
  assign lastIter = cnt == CW'(DATA_W - 1);
  assign stall    = (state == IDLE && mdGo)
                 || state == MUL || state == DIV;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (isMulOp)      stateNext = MUL;
        else if (isDivOp) stateNext = (opB == '0) ? DONE : DIV;
      end
      MUL, DIV: if (lastIter) stateNext = DONE;
      DONE:     stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // acc: mul = {partial product, remaining multiplier}
  //      div = {remainder, dividend/quotient bits}
  assign mulSum   = {1'b0, acc[2*DATA_W-1:DATA_W]}
                  + {1'b0, opMag & {DATA_W{acc[0]}}};
  assign divShift = acc[2*DATA_W-1:DATA_W-1];
  assign divTrial = divShift - {1'b0, opMag};
  assign divFits  = !divTrial[DATA_W];

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      opMag  <= '0;
      negRes <= 1'b0;
      divOp  <= 1'b0;
      rdReg  <= '0;
    end else begin
      unique case (state)
        IDLE: if (mdGo) begin
          cnt    <= '0;
          rdReg  <= rd;
          negRes <= opA[DATA_W-1] ^ opB[DATA_W-1];
          divOp  <= isDivOp;
          opMag  <= isDivOp ? magB : magA;
          acc    <= {{DATA_W{1'b0}}, isDivOp ? magA : magB};
        end
        MUL: begin
          acc <= {mulSum, acc[DATA_W-1:1]};
          cnt <= cnt + CW'(1);
        end
        DIV: begin
          acc <= {divFits ? divTrial[DATA_W-1:0] : divShift[DATA_W-1:0],
                  acc[DATA_W-2:0], divFits};
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // low half of the signed product equals the negated low half
  assign divZero = divOp && opMag == '0;
  assign resMag  = negRes ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  assign resNext = divZero ? '0 : resMag;

  always_ff @(posedge clock) begin
    if (reset) begin
      result       <= '0;
      result_valid <= 1'b0;
      result_rd    <= '0;
    end else begin
      result_valid <= state == DONE;
      if (state == DONE) begin
        result    <= resNext;
        result_rd <= rdReg;
      end
    end
  end

`ifdef MULTDIV_EXC_EN
  logic [2*DATA_W-1:0] prodS;
  logic                mulOvf;

  assign prodS  = negRes ? -acc : acc;
  assign mulOvf = prodS[2*DATA_W-1:DATA_W]
               != {DATA_W{prodS[DATA_W-1]}};

  always_ff @(posedge clock) begin
    if (reset) begin
      exc      <= 1'b0;
      exc_code <= '0;
    end else if (state == DONE) begin
      if (divOp) begin
        exc      <= divZero;
        exc_code <= divZero ? DATA_W'(5) : '0;
      end else begin
        exc      <= mulOvf;
        exc_code <= mulOvf ? DATA_W'(4) : '0;
      end
    end
  end
`else
  assign exc      = 1'b0;
  assign exc_code = '0;
`endif

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: randomized scoreboard bench for multdiv_sequencer.
// Expected responses come from plain signed arithmetic on 64-bit ints.
module tb_multdiv_sequencer;
  localparam int W = 32;
`ifdef MULTDIV_EXC_EN
  localparam bit ExcEn = 1'b1;
`else
  localparam bit ExcEn = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         issue = 1'b0;
  logic [4:0]   opcode = '0, aluop = '0, rd = '0;
  logic [W-1:0] opA = '0, opB = '0;
  logic         stall, result_valid, exc;
  logic [W-1:0] result, exc_code;
  logic [4:0]   result_rd;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        exc;
    logic [31:0] code;
  } exp_t;

  exp_t sbq[$];
  exp_t mon;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  multdiv_sequencer #(.DATA_W(W)) dut (
    .clock(clock), .reset(reset), .issue(issue),
    .opcode(opcode), .aluop(aluop), .rd(rd),
    .opA(opA), .opB(opB), .stall(stall),
    .result(result), .result_valid(result_valid),
    .result_rd(result_rd), .exc(exc), .exc_code(exc_code)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(bit isDiv, logic [31:0] a,
                                 logic [31:0] b, logic [4:0] d);
    exp_t   e;
    longint p;
    int     sa, sb, r;
    sa = a; sb = b;
    e.rd = d; e.exc = 1'b0; e.code = '0; e.res = '0;
    if (!isDiv) begin
      p = longint'(sa) * longint'(sb);
      r = int'(p);
      e.res = r;
      if (ExcEn && p != longint'(r)) begin
        e.exc = 1'b1; e.code = 4;
      end
    end else if (sb == 0) begin
      e.res = '0;
      if (ExcEn) begin
        e.exc = 1'b1; e.code = 5;
      end
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      e.res = a;
    end else begin
      e.res = sa / sb;
    end
    return e;
  endfunction

  always @(negedge clock) begin
    if (!reset && result_valid) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected result_valid: got rd=%0d result=%0h expected none",
                 result_rd, result);
      end else begin
        mon = sbq.pop_front();
        chk("result", result, mon.res);
        chk("result_rd", result_rd, mon.rd);
        chk("exc", exc, mon.exc);
        chk("exc_code", exc_code, mon.code);
      end
    end
  end

  task automatic doOp(bit isDiv, logic [31:0] a, logic [31:0] b,
                      logic [4:0] d, int hold);
    int n, sc, lat;
    @(negedge clock); #1;
    issue = 1'b1; opcode = 5'b00000;
    aluop = isDiv ? 5'b00111 : 5'b00110;
    rd = d; opA = a; opB = b;
    sbq.push_back(model(isDiv, a, b, d));
    lat = (isDiv && b == 0) ? 1 : 33;
    #1;
    chk("stall on issue", stall, 1);
    sc = stall;
    @(posedge clock); #1;
    rd = d ^ 5'h15; opA = a + 1;
    if (hold == 0) issue = 1'b0;
    n = 0;
    while (!result_valid && n < 100) begin
      sc += stall;
      @(posedge clock); #1;
      n++;
      if (n >= hold) issue = 1'b0;
    end
    issue = 1'b0;
    chk("latency", n, lat);
    chk("stall cycles", sc, lat);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h80000000;
      1: return 32'hFFFFFFFF;
      2: return 32'($urandom_range(0, 20));
      3: return 32'(0) - 32'($urandom_range(0, 20));
      4: return 32'($urandom_range(0, 70000));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int sc, nv;
    repeat (3) @(posedge clock);
    #1;
    chk("reset stall", stall, 0);
    chk("reset result_valid", result_valid, 0);
    chk("reset result", result, 0);
    chk("reset result_rd", result_rd, 0);
    chk("reset exc", exc, 0);
    chk("reset exc_code", exc_code, 0);
    reset = 1'b0;

    doOp(1'b0, 6, 7, 3, 0);
    doOp(1'b1, -12, 5, 9, 0);
    doOp(1'b1, 17, 0, 4, 0);
    doOp(1'b0, 32'h00010000, 32'h00010000, 5, 0);
    doOp(1'b0, -65536, 32768, 6, 0);
    doOp(1'b1, 32'h80000000, 32'hFFFFFFFF, 8, 0);
    doOp(1'b0, 123, -45, 10, 20);

    // abort a multiply mid-flight
    @(negedge clock); #1;
    issue = 1'b1; opcode = 5'b00000; aluop = 5'b00110;
    opA = 5; opB = 9; rd = 7;
    @(posedge clock); #1;
    issue = 1'b0;
    repeat (9) @(posedge clock);
    #1; reset = 1'b1;
    @(posedge clock); #1;
    chk("stall after abort", stall, 0);
    reset = 1'b0;
    nv = 0;
    repeat (40) begin
      @(posedge clock); #1;
      nv += result_valid;
    end
    chk("no valid after abort", nv, 0);
    doOp(1'b0, 3, 3, 11, 0);

    // non-md instructions must never stall
    @(negedge clock); #1;
    issue = 1'b1; opA = 2; opB = 3; rd = 12;
    sc = 0; nv = 0;
    for (int i = 0; i < 6; i++) begin
      opcode = (i % 2 == 0) ? 5'b00101 : 5'b00000;
      aluop  = (i % 2 == 0) ? 5'b00110 : 5'b00000;
      #1; sc += stall;
      @(posedge clock); #1;
      nv += result_valid;
    end
    issue = 1'b0;
    chk("non-md stall", sc, 0);
    repeat (3) begin
      @(posedge clock); #1;
      nv += result_valid;
    end
    chk("non-md valid", nv, 0);

    for (int i = 0; i < 24; i++)
      doOp(1'($urandom_range(0, 1)), pick(), pick(),
           5'($urandom_range(0, 31)), 0);

    repeat (5) @(posedge clock);
    chk("scoreboard drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
